cj_test_harness: RTL and testbench
==================================

CJ_TEST_HARNESS -- requirements
Module: cj_test_harness

Interface
REQ-001 SHALL have parameter XLEN, default 64: width of tohost, PC and write-data.
REQ-002 SHALL have parameter IDLE_LIMIT, default 50000: number of consecutive cycles with no commit that triggers the watchdog.
REQ-003 SHALL have parameter LOOP_LIMIT, default 1000: number of consecutive commits at the same PC that trigger hang detection.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 commit_valid  input  1  one instruction retired this cycle; the harness ties it to 0 when it is unused.
REQ-007 commit_pc  input  XLEN  PC of the retired instruction.
REQ-008 commit_wdata  input  XLEN  register write-back value of the retired instruction (0 if none).
REQ-009 host_wen  input  1  program store to the tohost address.
REQ-010 host_wdata  input  XLEN  value stored to tohost.
REQ-011 tohost  output  XLEN  completion word: bit0=1 means done; bits[XLEN-1:1] = exit code.
REQ-012 signature  output  XLEN  running commit signature.
REQ-013 commit_count  output  64  number of commits retired since reset.

Function
REQ-014 tohost SHALL be a register; bit0=1 is sticky until reset, and all later writes and detectors are ignored.
REQ-015 Host write: while tohost[0]=0, host_wen=1 SHALL load tohost with host_wdata on the next edge (1-cycle latency).
  - Loaded value = host_wdata, including values with bit0=0.
REQ-016 Watchdog: an idle counter SHALL clear on each commit_valid and otherwise increment, saturating at IDLE_LIMIT.
  - When it reaches IDLE_LIMIT with tohost[0]=0, tohost SHALL be set to 5 (code 2, done).
REQ-017 Hang: a loop counter SHALL increment when commit_valid=1 and commit_pc equals the last committed PC; any other commit SHALL clear it.
  - When it reaches LOOP_LIMIT, tohost SHALL be set to 7 (code 3, done).
REQ-018 Priority for a simultaneous event on one edge: host write > watchdog > hang; only one source updates tohost.
REQ-019 Signature: on commit_valid with tohost[0]=0, signature SHALL update to {signature rotated left by 1} XOR commit_pc XOR commit_wdata.
REQ-020 Counting: each qualifying commit SHALL increment commit_count by 1, wrapping modulo 2^64.
REQ-021 Freeze: after tohost[0]=1, signature, commit_count and all counters SHALL hold their values.
REQ-022 Last-PC register: updates on every qualifying commit and resets to 0.
  - A first commit at PC 0 therefore counts as a repeat.
REQ-023 The idle and loop counters SHALL be 32 bits wide.
  - Comparisons use >= so a reduced parameter value cannot overshoot.

Reset
REQ-024 While reset=1, the following SHALL all be cleared to 0 on the clock edge: tohost, signature, commit_count, idle counter, loop counter, last PC.
REQ-025 Reset asserted mid-run SHALL discard any done state; the next cycle after deassertion behaves as the first cycle after power-up.
REQ-026 Inputs SHALL be ignored while reset=1.

Structure
REQ-027 A shared package cj_pkg SHALL hold XLEN and the exit-code constants: EXIT_WATCHDOG=2, EXIT_HANG=3, and the done bit.
REQ-028 The signature and commit-count logic SHALL be one sub-module, cj_signature.
  - cj_test_harness holds the detectors and the tohost register.

Verification
REQ-029 Reset, then commit_valid=0 for 50000 cycles -> tohost=5 exactly when the idle counter reaches IDLE_LIMIT, then stays 5.
REQ-030 Commits at PC 0x80000000, 0x80000004, ...; then host_wen with host_wdata=1 -> tohost=1 one cycle later, and commit_count and signature freeze.
REQ-031 1000 consecutive commits at PC 0x80000010 -> tohost=7; a host write of 1 afterwards -> tohost stays 7.
REQ-032 On one edge: host_wen with host_wdata=3 plus the watchdog reaching its limit -> tohost=3.
REQ-033 Two commits {pc=1,wdata=0} then {pc=2,wdata=0} -> signature=0x1, then 0x0 (rotl(1)=2, XOR 2 = 0); commit_count=2.
REQ-034 Assert reset for 1 cycle after tohost=5 -> all outputs 0; the watchdog retriggers after a further IDLE_LIMIT idle cycles.

Source files
------------

// File: rtl/cj_pkg.sv
// Shared constants for the test harness: data width, exit codes and tohost source selection.
package cj_pkg;

    localparam int XLEN          = 64;
    localparam int DONE_BIT      = 0;
    localparam int EXIT_WATCHDOG = 2;
    localparam int EXIT_HANG     = 3;

    // Which source, if any, writes tohost on the current edge
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_HOST,
        SRC_WATCHDOG,
        SRC_HANG
    } tohost_src_e;

endpackage

// File: rtl/cj_signature.sv
// Running commit signature and retired-instruction counter; both advance only on qualifying commits.
module cj_signature #(
    parameter int XLEN = cj_pkg::XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            commit_en,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [XLEN-1:0] commit_wdata,
    output logic [XLEN-1:0] signature,
    output logic [63:0]     commit_count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            signature    <= '0;
            commit_count <= '0;
        end else if (commit_en) begin
            signature    <= {signature[XLEN-2:0], signature[XLEN-1]} ^ commit_pc ^ commit_wdata;
            commit_count <= commit_count + 64'd1;
        end
    end

endmodule

// File: rtl/cj_test_harness.sv
// Test completion harness: tohost register, idle watchdog and same-PC hang detector.
module cj_test_harness #(
    parameter int XLEN       = 64,
    parameter int IDLE_LIMIT = 50000,
    parameter int LOOP_LIMIT = 1000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [XLEN-1:0] commit_wdata,
    input  logic            host_wen,
    input  logic [XLEN-1:0] host_wdata,
    output logic [XLEN-1:0] tohost,
    output logic [XLEN-1:0] signature,
    output logic [63:0]     commit_count
);

    import cj_pkg::*;

    localparam logic [31:0]     IDLE_MAX      = 32'(IDLE_LIMIT);
    localparam logic [31:0]     LOOP_MAX      = 32'(LOOP_LIMIT);
    localparam logic [XLEN-1:0] WATCHDOG_WORD = XLEN'((EXIT_WATCHDOG << 1) | (1 << DONE_BIT));
    localparam logic [XLEN-1:0] HANG_WORD     = XLEN'((EXIT_HANG << 1) | (1 << DONE_BIT));

    logic            done;
    logic            commit_en;
    logic [31:0]     idle_count;
    logic [31:0]     idle_next;
    logic [31:0]     loop_count;
    logic [31:0]     loop_next;
    logic [XLEN-1:0] last_pc;
    tohost_src_e     src;

    assign done      = tohost[DONE_BIT];
    assign commit_en = commit_valid & ~done;

    // Detectors fire on the edge their counter reaches the limit, so they look at the next value
    always_comb begin
        idle_next = idle_count;
        loop_next = loop_count;
        src       = SRC_NONE;

        if (commit_valid) begin
            idle_next = '0;
        end else if (idle_count < IDLE_MAX) begin
            idle_next = idle_count + 32'd1;
        end

        if (commit_valid) begin
            if (commit_pc == last_pc) begin
                if (loop_count < LOOP_MAX) begin
                    loop_next = loop_count + 32'd1;
                end
            end else begin
                loop_next = '0;
            end
        end

        if (host_wen) begin
            src = SRC_HOST;
        end else if (idle_next >= IDLE_MAX) begin
            src = SRC_WATCHDOG;
        end else if (loop_next >= LOOP_MAX) begin
            src = SRC_HANG;
        end
    end

    // Once the done bit is set every piece of state holds until reset
    always_ff @(posedge clock) begin
        if (reset) begin
            tohost     <= '0;
            idle_count <= '0;
            loop_count <= '0;
            last_pc    <= '0;
        end else if (!done) begin
            idle_count <= idle_next;
            loop_count <= loop_next;
            if (commit_valid) begin
                last_pc <= commit_pc;
            end
            case (src)
                SRC_HOST:     tohost <= host_wdata;
                SRC_WATCHDOG: tohost <= WATCHDOG_WORD;
                SRC_HANG:     tohost <= HANG_WORD;
                default:      tohost <= tohost;
            endcase
        end
    end

    cj_signature #(
        .XLEN(XLEN)
    ) u_signature (
        .clock        (clock),
        .reset        (reset),
        .commit_en    (commit_en),
        .commit_pc    (commit_pc),
        .commit_wdata (commit_wdata),
        .signature    (signature),
        .commit_count (commit_count)
    );

endmodule

// File: tb/tb_cj_test_harness.sv
// Directed bench for cj_test_harness: vector table for signature/tohost plus watchdog, hang and reset sequences.
module tb_cj_test_harness;

    localparam int XLEN     = 64;
    localparam int IDLE_LIM = 2000;
    localparam int LOOP_LIM = 1000;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            commit_valid = 1'b0;
    logic [XLEN-1:0] commit_pc = '0;
    logic [XLEN-1:0] commit_wdata = '0;
    logic            host_wen = 1'b0;
    logic [XLEN-1:0] host_wdata = '0;
    logic [XLEN-1:0] tohost;
    logic [XLEN-1:0] signature;
    logic [63:0]     commit_count;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    cj_test_harness #(
        .XLEN       (XLEN),
        .IDLE_LIMIT (IDLE_LIM),
        .LOOP_LIMIT (LOOP_LIM)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_wdata (commit_wdata),
        .host_wen     (host_wen),
        .host_wdata   (host_wdata),
        .tohost       (tohost),
        .signature    (signature),
        .commit_count (commit_count)
    );

    typedef struct {
        string       name;
        logic        cv;
        logic [63:0] pc;
        logic [63:0] wd;
        logic        hw;
        logic [63:0] hd;
        logic [63:0] exp_tohost;
        logic [63:0] exp_sig;
        logic [63:0] exp_count;
    } vec_t;

    vec_t vecs[10];

    // Drive one cycle of inputs, then sample 1 ns after the rising edge
    task automatic applyStimulus(input logic cv, input logic [63:0] pc, input logic [63:0] wd,
                                 input logic hw, input logic [63:0] hd);
        commit_valid = cv;
        commit_pc    = pc;
        commit_wdata = wd;
        host_wen     = hw;
        host_wdata   = hd;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, '0);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] exp_sig;
        logic [63:0] pc;
        logic [63:0] wd;

        vecs[0] = '{"sig_pc1",      1'b1, 64'h1,  64'h0, 1'b0, 64'h0,  64'h0,  64'h1,  64'd1};
        vecs[1] = '{"sig_pc2",      1'b1, 64'h2,  64'h0, 1'b0, 64'h0,  64'h0,  64'h0,  64'd2};
        vecs[2] = '{"no_commit",    1'b0, 64'h5,  64'h7, 1'b0, 64'h0,  64'h0,  64'h0,  64'd2};
        vecs[3] = '{"sig_pc10",     1'b1, 64'h10, 64'h3, 1'b0, 64'h0,  64'h0,  64'h13, 64'd3};
        vecs[4] = '{"sig_pc20",     1'b1, 64'h20, 64'h0, 1'b0, 64'h0,  64'h0,  64'h06, 64'd4};
        vecs[5] = '{"host_even",    1'b1, 64'h0,  64'h8000000000000000, 1'b1, 64'h10,
                    64'h10, 64'h800000000000000C, 64'd5};
        vecs[6] = '{"rot_wrap",     1'b1, 64'h0,  64'h0, 1'b0, 64'h0,  64'h10, 64'h19, 64'd6};
        vecs[7] = '{"host_rewrite", 1'b0, 64'h0,  64'h0, 1'b1, 64'h2A, 64'h2A, 64'h19, 64'd6};
        vecs[8] = '{"host_done",    1'b1, 64'h4,  64'h1, 1'b1, 64'h0B, 64'h0B, 64'h37, 64'd7};
        vecs[9] = '{"frozen",       1'b1, 64'h8,  64'h0, 1'b1, 64'h0,  64'h0B, 64'h37, 64'd7};

        // Reset state, with junk on the inputs to show they are ignored
        reset = 1'b1;
        applyStimulus(1'b1, 64'h1234, 64'h5678, 1'b1, 64'h1);
        reset = 1'b0;
        checkOutput("reset_tohost", tohost, 64'h0);
        checkOutput("reset_sig", signature, 64'h0);
        checkOutput("reset_count", commit_count, 64'h0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].cv, vecs[i].pc, vecs[i].wd, vecs[i].hw, vecs[i].hd);
            checkOutput({vecs[i].name, "_tohost"}, tohost, vecs[i].exp_tohost);
            checkOutput({vecs[i].name, "_sig"}, signature, vecs[i].exp_sig);
            checkOutput({vecs[i].name, "_count"}, commit_count, vecs[i].exp_count);
        end

        // Watchdog fires on exactly the IDLE_LIM-th idle edge and then sticks
        doReset();
        idleCycles(IDLE_LIM - 1);
        checkOutput("wd_before_limit", tohost, 64'h0);
        idleCycles(1);
        checkOutput("wd_at_limit", tohost, 64'h5);
        applyStimulus(1'b1, 64'h40, 64'h0, 1'b1, 64'h1);
        idleCycles(3);
        checkOutput("wd_sticky", tohost, 64'h5);
        checkOutput("wd_count_frozen", commit_count, 64'h0);

        // Reset after done clears everything and the watchdog re-arms from scratch
        doReset();
        checkOutput("rst2_tohost", tohost, 64'h0);
        checkOutput("rst2_sig", signature, 64'h0);
        checkOutput("rst2_count", commit_count, 64'h0);
        idleCycles(IDLE_LIM - 1);
        checkOutput("rst2_wd_before", tohost, 64'h0);
        idleCycles(1);
        checkOutput("rst2_wd_at", tohost, 64'h5);

        // Sequential commits, then a host write of 1 freezes signature and count
        doReset();
        exp_sig = '0;
        for (int i = 0; i < 5; i++) begin
            pc = 64'h80000000 + 64'(4 * i);
            wd = 64'(i * 17);
            applyStimulus(1'b1, pc, wd, 1'b0, '0);
            exp_sig = {exp_sig[62:0], exp_sig[63]} ^ pc ^ wd;
        end
        checkOutput("seq_sig", signature, exp_sig);
        checkOutput("seq_count", commit_count, 64'd5);
        applyStimulus(1'b0, '0, '0, 1'b1, 64'h1);
        checkOutput("seq_host_done", tohost, 64'h1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 64'h80000100 + 64'(4 * i), 64'hFF, 1'b0, '0);
        end
        checkOutput("seq_sig_frozen", signature, exp_sig);
        checkOutput("seq_count_frozen", commit_count, 64'd5);

        // Repeated commits at one PC trip the hang detector; a later host write is ignored
        doReset();
        for (int i = 0; i < LOOP_LIM - 1; i++) begin
            applyStimulus(1'b1, 64'h80000010, 64'h0, 1'b0, '0);
        end
        checkOutput("hang_early", tohost, 64'h0);
        applyStimulus(1'b1, 64'h80000010, 64'h0, 1'b0, '0);
        applyStimulus(1'b1, 64'h80000010, 64'h0, 1'b0, '0);
        checkOutput("hang_fired", tohost, 64'h7);
        applyStimulus(1'b0, '0, '0, 1'b1, 64'h1);
        idleCycles(2);
        checkOutput("hang_sticky", tohost, 64'h7);

        // Host write wins over the watchdog reaching its limit on the same edge
        doReset();
        idleCycles(IDLE_LIM - 1);
        checkOutput("prio_before", tohost, 64'h0);
        applyStimulus(1'b0, '0, '0, 1'b1, 64'h3);
        checkOutput("prio_host_wins", tohost, 64'h3);
        idleCycles(5);
        checkOutput("prio_sticky", tohost, 64'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
